gbc_oam_dma_controller: RTL
===========================

Name: gbc_oam_dma_controller

Overview:
Sequences the GBC OAM DMA transfer triggered by a CPU write to $FF46. It copies Length bytes from (source page << 8) into OAM $FE00-$FE9F, one byte per machine cycle. While active it owns the memory bus read port and signals CPU lockout to the memory bus controller, which then permits CPU access to HRAM only. It sits between the CPU memory bus controller, the shared system memory read path (ROM/VRAM/WRAM), and the OAM RAM.

Parameters:
Length, 160, number of bytes per transfer; index width is clog2(Length).
EchoFold, 1, when 1, source pages $E0-$FF are folded to $C0-$DF (echo RAM); when 0, they are used verbatim.

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
ClkEn  in  1  one-Clk pulse per machine cycle; paces OAM writes
RegWrite  in  1  one-Clk strobe: CPU write to $FF46
RegData  in  8  source page written to $FF46
RegDout  out  8  $FF46 readback (last written page)
SrcAccess  out  1  read request to system memory, held until accepted
SrcAddress  out  16  source byte address
SrcReady  in  1  memory accepts request this Clk
SrcDataReady  in  1  SrcDin valid this Clk
SrcDin  in  8  source byte
OamWrite  out  1  one-Clk OAM write strobe
OamAddress  out  8  OAM index 0..Length-1
OamDout  out  8  OAM write data
Active  out  1  DMA owns bus; CPU restricted to HRAM

Behaviour:
- Reset (async, Reset_n low): state IDLE, index 0, page reg $FF, data latch 0, all strobes 0, Active 0, SrcAddress 0, OamAddress 0, OamDout 0. Reset mid-transfer aborts immediately; no further OAM writes occur.
- RegDout = page reg, always. Effective page = page - $20 when EchoFold and page >= $E0; otherwise page. Page reg update ignores ClkEn.
- SrcAddress = {effective page, index zero-extended to 8 bits}. OamAddress = index.
- States:
  - IDLE: Active 0. RegWrite -> latch page, index <= 0, go START.
  - START: Active 1. Wait for ClkEn, then go READ. This is the one-machine-cycle startup delay.
  - READ: SrcAccess 1. When SrcReady, go WAIT. SrcAccess drops the next Clk.
  - WAIT: when SrcDataReady, latch SrcDin into OamDout, go WRITE. If SrcReady and SrcDataReady arrive in the same Clk in READ, latch the data and go straight to WRITE.
  - WRITE: wait for ClkEn, then pulse OamWrite for 1 Clk with the current index/data. If index == Length-1, go IDLE; otherwise index++ and go READ.
- Active = (state != IDLE), registered. It deasserts the Clk after the final OamWrite.
- Throughput: at most one OamWrite per ClkEn. With zero-wait memory and a ClkEn period of at least 3 Clk, a transfer spans exactly Length+1 ClkEn pulses from RegWrite to Active fall.
- Slow memory: if the source has not delivered by the next ClkEn, that machine cycle is skipped. No byte is ever dropped or duplicated.
- Restart: RegWrite in any non-IDLE state latches the new page, sets index 0, and goes START. Active stays 1.
  - If RegWrite coincides with an OamWrite, that write still completes (old data, old index); the restart then takes effect.
  - An outstanding source read in WAIT is discarded: the FSM leaves WAIT and ignores the late SrcDataReady.
- RegWrite and ClkEn in the same Clk while IDLE: go START. The startup ClkEn is the next pulse, not this one.
- Index never exceeds Length-1. No wrap occurs within a transfer.

Test Plan:
- Reset -> RegDout=$FF, Active=0, OamWrite=0, SrcAccess=0. Assert Reset_n low mid-transfer at index 50 -> all outputs return to reset values the same Clk.
- Write $C1, zero-wait memory returning (addr[7:0]^$5A), ClkEn every 4 Clk -> 160 OamWrites at OAM 0..159 with data i^$5A, SrcAddress $C100..$C19F, Active high for exactly 161 ClkEn pulses.
- Write $E3 with EchoFold=1 -> SrcAddress $C300..$C39F. With EchoFold=0 -> $E300..$E39F.
- SrcDataReady delayed 6 Clk on byte 10, with ClkEn every 4 Clk -> byte 10 written on the next ClkEn after data arrives, total 162 pulses, no gap or repeat in OamAddress.
- Write $80, then write $D0 during byte 40 while in WAIT -> late data discarded, next OamWrite is index 0 from $D000, Active never drops, 160 writes from $D0 page.
- RegWrite coincident with the OamWrite of index 159 -> index 159 written, Active stays 1, new transfer starts with START.

Source files
------------

// File: rtl/gbc_oam_dma_controller.sv
// OAM DMA sequencer: copies Length bytes from (page << 8) into OAM, at most one byte per ClkEn pulse.
// Source reads wait for SrcReady/SrcDataReady; a byte that arrives late costs whole machine cycles, never a byte.
module gbc_oam_dma_controller #(
    parameter int Length   = 160,
    parameter bit EchoFold = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ClkEn,
    input  logic        RegWrite,
    input  logic [7:0]  RegData,
    output logic [7:0]  RegDout,
    output logic        SrcAccess,
    output logic [15:0] SrcAddress,
    input  logic        SrcReady,
    input  logic        SrcDataReady,
    input  logic [7:0]  SrcDin,
    output logic        OamWrite,
    output logic [7:0]  OamAddress,
    output logic [7:0]  OamDout,
    output logic        Active
);

    localparam int IdxW = (Length > 1) ? $clog2(Length) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Length - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      page;
    logic [IdxW-1:0] index;
    logic [IdxW-1:0] index_nxt;
    logic [7:0]      index_nxt_ext;
    logic [7:0]      index_ext;
    logic [7:0]      data_q;
    logic [15:0]     src_addr_q;
    logic            write_fire;
    logic            accept_dat;

    // Echo RAM ($E0-$FF) mirrors WRAM ($C0-$DF) when folding is enabled.
    function automatic logic [7:0] eff_page(input logic [7:0] p);
        if (EchoFold && (p >= 8'hE0)) begin
            return p - 8'h20;
        end
        return p;
    endfunction

    assign write_fire = (state == ST_WRITE) && ClkEn;
    // A restart discards any byte landing in the same Clk.
    assign accept_dat = !RegWrite && SrcDataReady &&
                        (((state == ST_READ) && SrcReady) || (state == ST_WAIT));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_START: if (ClkEn) state_nxt = ST_READ;
            ST_READ: begin
                if (SrcReady) begin
                    state_nxt = SrcDataReady ? ST_WRITE : ST_WAIT;
                end
            end
            ST_WAIT:  if (SrcDataReady) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (ClkEn) begin
                    state_nxt = (index == LastIdx) ? ST_IDLE : ST_READ;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (RegWrite) begin
            state_nxt = ST_START;
        end
    end

    always_comb begin
        SrcAccess = (state == ST_READ);
        OamWrite  = write_fire;
        Active    = (state != ST_IDLE);
    end

    always_comb begin
        index_nxt = index;
        if (RegWrite) begin
            index_nxt = '0;
        end else if (write_fire && (index != LastIdx)) begin
            index_nxt = index + 1'b1;
        end
    end

    always_comb begin
        index_ext                = '0;
        index_ext[IdxW-1:0]      = index;
        index_nxt_ext            = '0;
        index_nxt_ext[IdxW-1:0]  = index_nxt;
    end

    // Source address is captured on entry to READ so it stays stable while the request is held.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            page       <= 8'hFF;
            index      <= '0;
            data_q     <= 8'h00;
            src_addr_q <= 16'h0000;
        end else begin
            if (RegWrite) begin
                page <= RegData;
            end
            index <= index_nxt;
            if (accept_dat) begin
                data_q <= SrcDin;
            end
            if (state_nxt == ST_READ) begin
                src_addr_q <= {eff_page(page), index_nxt_ext};
            end
        end
    end

    assign RegDout    = page;
    assign SrcAddress = src_addr_q;
    assign OamAddress = index_ext;
    assign OamDout    = data_q;

    a_index_bound: assert property (@(posedge Clk) disable iff (!Reset_n)
        index <= LastIdx);

    a_req_held: assert property (@(posedge Clk) disable iff (!Reset_n)
        (SrcAccess && !SrcReady && !RegWrite) |=> SrcAccess);

    a_idle_quiet: assert property (@(posedge Clk) disable iff (!Reset_n)
        (state == ST_IDLE) |-> (!OamWrite && !SrcAccess));

endmodule
